// File: rtl/ip_checksum_8bit_acc_if.sv
// Byte-strobe bus for the IP checksum accumulator.
// The master drives the tagged byte stream; the slave (accumulator) returns the checksum.
interface ip_checksum_8bit_acc_if;
  logic        dv_even;
  logic        dv_odd;
  logic [7:0]  data;
  logic [15:0] checksum;

  modport master (
    output dv_even,
    output dv_odd,
    output data,
    input  checksum
  );

  modport slave (
    input  dv_even,
    input  dv_odd,
    input  data,
    output checksum
  );
endinterface

// File: rtl/ip_checksum_8bit_acc.sv
// ip_checksum_8bit_acc
// Byte-serial RFC 1071 one's-complement checksum accumulator.
// Bytes tagged even land in the high half of a 16-bit word, odd bytes in the low
// half; both strobes together add the byte to both halves. The running sum uses
// end-around carry and the checksum is its complement.
// Optional feature macro: UDP_ZERO_SUBST_EN -- when defined, a computed checksum
// of 16'h0000 is sent as 16'hFFFF (UDP "zero means no checksum" rule).
module ip_checksum_8bit_acc #(
  parameter logic [15:0] INIT_SUM = 16'h0000
) (
  input  logic                   clk,
  input  logic                   reset,
  ip_checksum_8bit_acc_if.slave  bus
);

  logic [15:0] acc;
  logic [15:0] addend;
  logic [16:0] sum_wide;
  logic [15:0] acc_next;
  logic [15:0] acc_inv;

  // Place the incoming byte into the word half (or halves) selected by the strobes.
  always_comb begin
    addend = 16'h0000;
    unique case ({bus.dv_even, bus.dv_odd})
      2'b10:   addend = {bus.data, 8'h00};
      2'b01:   addend = {8'h00, bus.data};
      2'b11:   addend = {bus.data, bus.data};
      default: addend = 16'h0000;
    endcase
  end

  // One's-complement add: fold the carry out of bit 15 back into bit 0.
  // The fold cannot overflow because a carry-out implies the low half is at most 16'hFFFE.
  always_comb begin
    sum_wide = {1'b0, acc} + {1'b0, addend};
    acc_next = sum_wide[15:0] + {15'd0, sum_wide[16]};
  end

  // Running sum register; reset wins over any strobe in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= INIT_SUM;
    end else if (bus.dv_even || bus.dv_odd) begin
      acc <= acc_next;
    end
  end

  // Present the complemented sum, optionally substituting all-ones for a zero result.
  always_comb begin
    acc_inv = ~acc;
`ifdef UDP_ZERO_SUBST_EN
    if (acc_inv == 16'h0000) begin
      bus.checksum = 16'hFFFF;
    end else begin
      bus.checksum = acc_inv;
    end
`else
    bus.checksum = acc_inv;
`endif
  end

endmodule

// File: tb/tb_ip_checksum_8bit_acc.sv
// tb_ip_checksum_8bit_acc
// Directed self-checking bench for the byte-serial IP checksum accumulator.
// Honours UDP_ZERO_SUBST_EN when choosing the expected zero-result checksum.
module tb_ip_checksum_8bit_acc;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [7:0] hdr [20];

  ip_checksum_8bit_acc_if bus ();

  ip_checksum_8bit_acc #(
    .INIT_SUM (16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs at the falling edge and return just after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic even, input logic odd,
                               input logic [7:0] d);
    @(negedge clk);
    reset       = rst;
    bus.dv_even = even;
    bus.dv_odd  = odd;
    bus.data    = d;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    bus.dv_even = 1'b0;
    bus.dv_odd  = 1'b0;
  endtask

  // Compare the checksum output against a hand-computed value.
  task automatic checkOutput(input string tag, input logic [15:0] expected);
    checks++;
    assert (bus.checksum === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, bus.checksum, expected);
    end
  endtask

  // Stream the first n header bytes, alternating even/odd starting with even, back-to-back.
  task automatic sendStream(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, (i % 2) == 0, (i % 2) == 1, hdr[i]);
    end
  endtask

  initial begin
    logic [15:0] zero_expect;
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    bus.dv_even = 1'b0;
    bus.dv_odd  = 1'b0;
    bus.data    = 8'h00;
    hdr = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
            8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
`ifdef UDP_ZERO_SUBST_EN
    zero_expect = 16'hFFFF;
`else
    zero_expect = 16'h0000;
`endif

    $display("[TB] reset state");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("reset", 16'hFFFF);

    $display("[TB] data ignored without strobes");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hA5);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h5A);
    checkOutput("idle_noise", 16'hFFFF);

    $display("[TB] IPv4 header stream");
    sendStream(20);
    checkOutput("hdr_stream", 16'hB861);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF);
    checkOutput("hdr_hold", 16'hB861);

    $display("[TB] end-around carry");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("carry_reset", 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF);
    checkOutput("carry_hi_ff", 16'h00FF);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h01);
    checkOutput("carry_wrap", 16'hFFFE);

    $display("[TB] simultaneous strobes");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h12);
    checkOutput("both_strobes", 16'hEDED);

    $display("[TB] repeated even strobes");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01);
    checkOutput("even_even", 16'hFDFF);

    $display("[TB] odd byte before even byte");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h34);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h12);
    checkOutput("odd_then_even", 16'hEDCB);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    sendStream(3);
    checkOutput("partial_3", 16'hBAFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h45);
    checkOutput("mid_reset", 16'hFFFF);
    sendStream(20);
    checkOutput("hdr_rerun", 16'hB861);

    $display("[TB] zero checksum result");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("zero_result", zero_expect);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
